iob_pcie_tx_arb: RTL

- Single-clock TX engine. Arbitrates N_SRC CPU-side producer streams onto one RIFFA-style PCIe TX channel.
- Packs DATA_W-bit source words into PCI_DATA_W-bit beats.
- Runs the full TX transaction handshake (TX/ACK, LEN, DATA_VALID/REN, LAST) per message.
- Successor of the fixed 32->64, single-source TX path: generalised widths, source count, round-robin fairness, length counting, tail padding.

---
 rtl/iob_pcie_tx_pkg.sv | 25 ++
 rtl/iob_pcie_tx_packer.sv | 75 +++++++
 rtl/iob_pcie_tx_arb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/iob_pcie_tx_pkg.sv
`default_nettype none
// ============================================================================
// iob_pcie_tx_pkg: shared FSM encoding and width helpers for the PCIe TX arbiter
// Rev 1.0
// ============================================================================
package iob_pcie_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_t;

    function automatic int beat_ratio(input int pci_w, input int data_w);
        return pci_w / data_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_pcie_tx_packer.sv
`default_nettype none
// ============================================================================
// iob_pcie_tx_packer: packs DATA_W words LSB-first into PCI_DATA_W beats
// Rev 1.0
// ============================================================================
module iob_pcie_tx_packer
    import iob_pcie_tx_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PCI_DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    input  logic                  last,
    input  logic [DATA_W-1:0]     word,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [PCI_DATA_W-1:0] tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_data_ren,
    output logic                  idle
);

    localparam int R   = beat_ratio(PCI_DATA_W, DATA_W);
    localparam int K_W = idx_width(R);

    logic [K_W-1:0]        slot;
    logic                  asm_full;
    logic [PCI_DATA_W-1:0] asm_q;
    logic [PCI_DATA_W-1:0] asm_wr;
    logic                  move;
    logic                  accept;
    logic                  complete;

    // A full assembly can accept a new word only in the cycle it moves out.
    always_comb begin
        move       = asm_full && (!tx_data_valid || tx_data_ren);
        word_ready = en && (!asm_full || move);
        accept     = word_ready && word_valid;
        complete   = accept && ((slot == K_W'(R - 1)) || last);
        asm_wr     = move ? '0 : asm_q;
        asm_wr[int'(slot)*DATA_W +: DATA_W] = word;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            slot          <= '0;
            asm_full      <= 1'b0;
            asm_q         <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
        end else begin
            if (move) begin
                tx_data       <= asm_q;
                tx_data_valid <= 1'b1;
            end else if (tx_data_ren) begin
                tx_data_valid <= 1'b0;
            end

            if (accept) begin
                asm_q    <= asm_wr;
                asm_full <= complete;
                slot     <= complete ? '0 : slot + K_W'(1);
            end else if (move) begin
                asm_q    <= '0;
                asm_full <= 1'b0;
            end
        end
    end

    assign idle = !asm_full && !tx_data_valid;

endmodule
`default_nettype wire

// File: rtl/iob_pcie_tx_arb.sv
`default_nettype none
// ============================================================================
// iob_pcie_tx_arb: round-robin N-source RIFFA PCIe TX engine (optional ack
// watchdog: IOB_PCIE_TX_TIMEOUT_EN)     Rev 1.0
// ============================================================================
module iob_pcie_tx_arb
    import iob_pcie_tx_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int DATA_W     = 32,
    parameter int PCI_DATA_W = 64,
    parameter int LEN_W      = 32,
    parameter int OFF_W      = 31,
    parameter int TIMEOUT_W  = 16,
    localparam int IDX_W     = idx_width(N_SRC)
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [N_SRC-1:0]        src_req_i,
    input  logic [N_SRC*LEN_W-1:0]  src_len_i,
    output logic [N_SRC-1:0]        src_gnt_o,
    input  logic [N_SRC*DATA_W-1:0] src_data_i,
    input  logic [N_SRC-1:0]        src_valid_i,
    output logic [N_SRC-1:0]        src_ready_o,
    output logic [N_SRC-1:0]        src_done_o,
    output logic [N_SRC-1:0]        src_err_o,
    output logic [IDX_W-1:0]        cur_src_o,
    output logic                    busy_o,
    output logic                    tx_o,
    input  logic                    tx_ack_i,
    output logic                    tx_last_o,
    output logic [LEN_W-1:0]        tx_len_o,
    output logic [OFF_W-1:0]        tx_off_o,
    output logic [PCI_DATA_W-1:0]   tx_data_o,
    output logic                    tx_data_valid_o,
    input  logic                    tx_data_ren_i
);

    tx_state_t        state;
    tx_state_t        state_n;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] gnt_next_idx;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] remaining;
    logic [N_SRC-1:0] gnt_vec;
    logic [DATA_W-1:0] word;
    logic             word_valid;
    logic             pk_ready;
    logic             pk_idle;
    logic             accept;
    logic             timeout;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_SRC);
            if (!found && src_req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            gnt_vec[i] = (int'(gnt_idx) == i);
        end
    end

    assign gnt_next_idx = (int'(gnt_idx) == N_SRC - 1) ? '0 : gnt_idx + IDX_W'(1);
    assign word         = src_data_i[int'(gnt_idx)*DATA_W +: DATA_W];
    assign word_valid   = |(src_valid_i & gnt_vec);
    assign accept       = word_valid && pk_ready;

`ifdef IOB_PCIE_TX_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);
    logic [TIMEOUT_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            to_cnt <= '0;
        end else if (state == ST_REQ && !tx_ack_i) begin
            to_cnt <= to_cnt + TIMEOUT_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // Fires in the cycle the counter would reach its all-ones value.
    assign timeout   = (state == ST_REQ) && !tx_ack_i && (to_cnt == TO_LAST);
    assign src_err_o = timeout ? gnt_vec : '0;
`else
    logic unused_timeout_w;
    assign unused_timeout_w = (TIMEOUT_W > 0);
    assign timeout          = 1'b0;
    assign src_err_o        = '0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (found) state_n = ST_REQ;
            ST_REQ: begin
                if (tx_ack_i) begin
                    state_n = (len_q == '0) ? ST_DONE : ST_DATA;
                end else if (timeout) begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA:  if (accept && remaining == LEN_W'(1)) state_n = ST_DRAIN;
            ST_DRAIN: if (pk_idle) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            len_q     <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt_idx   <= pick;
                        len_q     <= src_len_i[int'(pick)*LEN_W +: LEN_W];
                        remaining <= src_len_i[int'(pick)*LEN_W +: LEN_W];
                    end
                end
                ST_REQ:  if (timeout) rr_ptr <= gnt_next_idx;
                ST_DATA: if (accept) remaining <= remaining - LEN_W'(1);
                ST_DONE: rr_ptr <= gnt_next_idx;
                default: ;
            endcase
        end
    end

    iob_pcie_tx_packer #(
        .DATA_W     (DATA_W),
        .PCI_DATA_W (PCI_DATA_W)
    ) u_packer (
        .clk           (clk),
        .arst_n        (arst_n),
        .en            (state == ST_DATA),
        .last          (remaining == LEN_W'(1)),
        .word          (word),
        .word_valid    (word_valid),
        .word_ready    (pk_ready),
        .tx_data       (tx_data_o),
        .tx_data_valid (tx_data_valid_o),
        .tx_data_ren   (tx_data_ren_i),
        .idle          (pk_idle)
    );

    assign busy_o      = (state != ST_IDLE);
    assign src_gnt_o   = busy_o ? gnt_vec : '0;
    assign src_ready_o = pk_ready ? gnt_vec : '0;
    assign src_done_o  = (state == ST_DONE) ? gnt_vec : '0;
    assign cur_src_o   = gnt_idx;
    assign tx_o        = (state == ST_REQ);
    assign tx_len_o    = len_q;
    assign tx_off_o    = '0;
    assign tx_last_o   = 1'b1;

endmodule
`default_nettype wire
